// File: rtl/usb_boot_supervisor.sv
// usb_boot_supervisor
//   Reset and boot supervisor for the USB bootloader top level. It holds the
//   USB engine in reset for a fixed time after power-on. It times host presence
//   from SOF pulses. It then launches a warm boot through SB_WARMBOOT, either on
//   a host timeout or on an explicit request. The image select is set up before
//   BOOT is triggered.
//
// Ports
//   clk             in   48 MHz USB clock
//   reset_n         in   asynchronous active-low reset
//   sof_valid       in   one-cycle pulse per received SOF
//   boot_req        in   boot_to_user_design request (level or pulse)
//   boot_image      in   [1:0] image {S1,S0} used when boot_req is accepted
//   timeout_disable in   1 = host timer frozen at 0
//   usb_reset       out  active-high synchronous reset to the USB engine/endpoints
//   host_seen       out  sticky: at least one SOF since POR exit
//   warmboot_s      out  [1:0] SB_WARMBOOT {S1,S0}
//   warmboot_boot   out  SB_WARMBOOT BOOT
//   boot_cause      out  [1:0] 0 none, 1 host timeout, 2 explicit request
//
// state       | meaning
// ST_POR      | usb_reset held high while por_cnt runs
// ST_WAIT_HOST| engine running, no SOF seen yet, host timer running
// ST_ACTIVE   | at least one SOF seen, host timer running
// ST_BOOT_SETUP| image/cause latched, warmboot_s settling before BOOT
// ST_BOOT_FIRE| warmboot_boot asserted; terminal until reset_n

module usb_boot_supervisor #(
  parameter int unsigned POR_CYCLES          = 4096,
  parameter int unsigned HOST_TIMEOUT_CYCLES = 48000000,
  parameter logic [1:0]  DEFAULT_IMAGE       = 2'b01,
  parameter int unsigned SETUP_CYCLES        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sof_valid,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       timeout_disable,
  output logic       usb_reset,
  output logic       host_seen,
  output logic [1:0] warmboot_s,
  output logic       warmboot_boot,
  output logic [1:0] boot_cause
);

  localparam int POR_W  = $clog2(POR_CYCLES + 1);
  localparam int HOST_W = $clog2(HOST_TIMEOUT_CYCLES + 1);
  localparam int SET_W  = $clog2(SETUP_CYCLES + 1);

  localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
  localparam logic [HOST_W-1:0] HOST_LAST = HOST_W'(HOST_TIMEOUT_CYCLES - 1);
  localparam logic [HOST_W-1:0] HOST_MAX  = HOST_W'(HOST_TIMEOUT_CYCLES);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETUP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_POR,
    ST_WAIT_HOST,
    ST_ACTIVE,
    ST_BOOT_SETUP,
    ST_BOOT_FIRE
  } state_t;

  state_t             state, state_nxt;
  logic [POR_W-1:0]   por_cnt, por_cnt_nxt;
  logic [HOST_W-1:0]  host_tmr, host_tmr_nxt;
  logic [SET_W-1:0]   set_cnt, set_cnt_nxt;
  logic               usb_reset_nxt, host_seen_nxt, warmboot_boot_nxt;
  logic [1:0]         warmboot_s_nxt, boot_cause_nxt;
  logic               timeout_hit;

  // A SOF in the terminal cycle clears the timer instead of timing out.
  assign timeout_hit = !timeout_disable && !sof_valid && (host_tmr == HOST_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_POR;
      por_cnt       <= '0;
      host_tmr      <= '0;
      set_cnt       <= '0;
      usb_reset     <= 1'b1;
      host_seen     <= 1'b0;
      warmboot_s    <= 2'b00;
      warmboot_boot <= 1'b0;
      boot_cause    <= 2'd0;
    end else begin
      state         <= state_nxt;
      por_cnt       <= por_cnt_nxt;
      host_tmr      <= host_tmr_nxt;
      set_cnt       <= set_cnt_nxt;
      usb_reset     <= usb_reset_nxt;
      host_seen     <= host_seen_nxt;
      warmboot_s    <= warmboot_s_nxt;
      warmboot_boot <= warmboot_boot_nxt;
      boot_cause    <= boot_cause_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    por_cnt_nxt       = por_cnt;
    host_tmr_nxt      = host_tmr;
    set_cnt_nxt       = set_cnt;
    usb_reset_nxt     = usb_reset;
    host_seen_nxt     = host_seen;
    warmboot_s_nxt    = warmboot_s;
    warmboot_boot_nxt = warmboot_boot;
    boot_cause_nxt    = boot_cause;

    case (state)
      ST_POR: begin
        if (por_cnt == POR_LAST) begin
          state_nxt     = ST_WAIT_HOST;
          usb_reset_nxt = 1'b0;
        end else begin
          por_cnt_nxt = por_cnt + POR_W'(1);
        end
      end

      ST_WAIT_HOST, ST_ACTIVE: begin
        if (timeout_disable || sof_valid) begin
          host_tmr_nxt = '0;
        end else if (host_tmr != HOST_MAX) begin
          host_tmr_nxt = host_tmr + HOST_W'(1);
        end

        if (sof_valid) begin
          host_seen_nxt = 1'b1;
          if (state == ST_WAIT_HOST) state_nxt = ST_ACTIVE;
        end

        // An explicit request outranks a simultaneous timeout.
        if (boot_req) begin
          state_nxt      = ST_BOOT_SETUP;
          boot_cause_nxt = 2'd2;
          warmboot_s_nxt = boot_image;
        end else if (timeout_hit) begin
          state_nxt      = ST_BOOT_SETUP;
          boot_cause_nxt = 2'd1;
          warmboot_s_nxt = DEFAULT_IMAGE;
        end
      end

      ST_BOOT_SETUP: begin
        if (set_cnt == SET_LAST) begin
          state_nxt         = ST_BOOT_FIRE;
          warmboot_boot_nxt = 1'b1;
        end else begin
          set_cnt_nxt = set_cnt + SET_W'(1);
        end
      end

      ST_BOOT_FIRE: begin
      end

      default: state_nxt = ST_POR;
    endcase
  end

endmodule

// File: tb/tb_usb_boot_supervisor.sv
module tb_usb_boot_supervisor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sof_valid;
  logic       boot_req;
  logic [1:0] boot_image;
  logic       timeout_disable;
  logic       usb_reset;
  logic       host_seen;
  logic [1:0] warmboot_s;
  logic       warmboot_boot;
  logic [1:0] boot_cause;

  int n_checks = 0;
  int n_pass   = 0;

  usb_boot_supervisor #(
    .POR_CYCLES          (8),
    .HOST_TIMEOUT_CYCLES (20),
    .DEFAULT_IMAGE       (2'b01),
    .SETUP_CYCLES        (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sof_valid       (sof_valid),
    .boot_req        (boot_req),
    .boot_image      (boot_image),
    .timeout_disable (timeout_disable),
    .usb_reset       (usb_reset),
    .host_seen       (host_seen),
    .warmboot_s      (warmboot_s),
    .warmboot_boot   (warmboot_boot),
    .boot_cause      (boot_cause)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_usb_reset"}, int'(usb_reset), 1);
    chk({tag, "_host_seen"}, int'(host_seen), 0);
    chk({tag, "_wb_s"}, int'(warmboot_s), 0);
    chk({tag, "_wb_boot"}, int'(warmboot_boot), 0);
    chk({tag, "_cause"}, int'(boot_cause), 0);
  endtask

  // Restart: assert reset, release it, then run out the 8-cycle POR.
  task automatic do_por(input string tag);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(7);
    chk({tag, "_usb_reset_hi7"}, int'(usb_reset), 1);
    tick(1);
    chk({tag, "_usb_reset_lo8"}, int'(usb_reset), 0);
  endtask

  initial begin
    int cnt;
    int bad;
    reset_n         = 1'b0;
    sof_valid       = 1'b0;
    boot_req        = 1'b0;
    boot_image      = 2'b00;
    timeout_disable = 1'b0;

    // 1: reset values and POR length
    tick(2);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    cnt = 0;
    while (usb_reset && cnt < 50) begin
      tick(1);
      cnt++;
    end
    chk("por_len", cnt, 8);
    chk("por_host_seen", int'(host_seen), 0);
    chk("por_cause", int'(boot_cause), 0);
    chk("por_boot", int'(warmboot_boot), 0);

    // 2: no SOF -> timeout at 20 cycles after POR exit
    tick(19);
    chk("to_c19_cause", int'(boot_cause), 0);
    tick(1);
    chk("to_c20_cause", int'(boot_cause), 1);
    chk("to_c20_s", int'(warmboot_s), 1);
    chk("to_c20_boot", int'(warmboot_boot), 0);
    tick(3);
    chk("to_c23_boot", int'(warmboot_boot), 0);
    tick(1);
    chk("to_c24_boot", int'(warmboot_boot), 1);
    chk("to_host_seen", int'(host_seen), 0);
    boot_req = 1'b1; boot_image = 2'b11; sof_valid = 1'b1;
    tick(10);
    boot_req = 1'b0; sof_valid = 1'b0;
    chk("fire_hold_boot", int'(warmboot_boot), 1);
    chk("fire_hold_s", int'(warmboot_s), 1);
    chk("fire_hold_cause", int'(boot_cause), 1);

    // 3: periodic SOF keeps the host alive
    do_por("p3");
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      sof_valid = (i % 15 == 14);
      tick(1);
      if (boot_cause != 2'd0 || warmboot_boot) bad++;
    end
    sof_valid = 1'b0;
    chk("sof_no_boot", bad, 0);
    chk("sof_host_seen", int'(host_seen), 1);
    sof_valid = 1'b1;
    tick(1);
    sof_valid = 1'b0;
    tick(19);
    sof_valid = 1'b1;           // lands on the tmr=19 cycle
    tick(1);
    sof_valid = 1'b0;
    chk("sof_coincide_cause", int'(boot_cause), 0);
    tick(19);
    chk("last_sof_c19", int'(boot_cause), 0);
    tick(1);
    chk("last_sof_c20", int'(boot_cause), 1);
    chk("last_sof_s", int'(warmboot_s), 1);

    // 4: request coincident with timeout -> request wins
    do_por("p4");
    sof_valid = 1'b1;
    tick(1);
    sof_valid = 1'b0;
    tick(19);
    boot_req = 1'b1; boot_image = 2'b10;
    tick(1);
    boot_req = 1'b0; boot_image = 2'b00;
    chk("req_cause", int'(boot_cause), 2);
    chk("req_s", int'(warmboot_s), 2);
    chk("req_host_seen", int'(host_seen), 1);
    tick(3);
    chk("req_c3_boot", int'(warmboot_boot), 0);
    tick(1);
    chk("req_c4_boot", int'(warmboot_boot), 1);

    // 5: request during POR ignored
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    boot_req = 1'b1; boot_image = 2'b11;
    tick(1);
    boot_req = 1'b0; boot_image = 2'b00;
    tick(4);
    chk("p5_usb_reset", int'(usb_reset), 0);
    chk("p5_cause_post_por", int'(boot_cause), 0);
    tick(19);
    chk("p5_c19_cause", int'(boot_cause), 0);
    tick(1);
    chk("p5_c20_cause", int'(boot_cause), 1);
    chk("p5_s", int'(warmboot_s), 1);

    // 6: reset mid-setup cancels boot, then timeout_disable
    tick(2);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_setup");
    tick(5);
    chk("rst_hold_boot", int'(warmboot_boot), 0);
    reset_n = 1'b1;
    timeout_disable = 1'b1;
    tick(7);
    chk("p6_usb_reset_hi7", int'(usb_reset), 1);
    tick(1);
    chk("p6_usb_reset_lo8", int'(usb_reset), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (boot_cause != 2'd0 || warmboot_boot) bad++;
    end
    chk("tdis_no_boot", bad, 0);
    timeout_disable = 1'b0;
    tick(19);
    chk("tdis_off_c19", int'(boot_cause), 0);
    tick(1);
    chk("tdis_off_c20", int'(boot_cause), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
